// File: rtl/image_loader_if.sv
// Image word stream between the input source and the loader.
interface image_loader_if #(
    parameter int unsigned IN_W = 8
);
    logic            in_valid;
    logic [IN_W-1:0] in_data;
    logic            in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/image_loader.sv
// Packs the binarised input image into the layer-1 pixel register while the
// sequencer is in LOAD, then pulses load_done once the last word is captured.
module image_loader #(
    parameter  int unsigned IMG_BITS = 784,
    parameter  int unsigned IN_W     = 8,
    localparam int unsigned WORDS    = (IMG_BITS + IN_W - 1) / IN_W,
    localparam int unsigned CW       = $clog2(WORDS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          state,
    image_loader_if.slave       bus,
    output logic                load_done,
    output logic [CW-1:0]       rx_count,
    output logic [IMG_BITS-1:0] pixels
);
    localparam logic [2:0]  SEQ_LOAD = 3'b001;
    // Word-aligned scratch width; any tail bits past IMG_BITS are dropped.
    localparam int unsigned PAD_W    = WORDS * IN_W;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_RECV = 2'd1,
        L_DONE = 2'd2
    } lstate_e;

    lstate_e             lstate_q, lstate_d;
    logic [CW-1:0]       rx_count_q, rx_count_d;
    logic [IMG_BITS-1:0] pixels_q, pixels_d;
    logic                load_done_q, load_done_d;
    logic                in_ready_c;
    logic [PAD_W-1:0]    pix_pad_c;

    // State register and captured image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstate_q    <= L_IDLE;
            rx_count_q  <= '0;
            pixels_q    <= '0;
            load_done_q <= 1'b0;
        end else begin
            lstate_q    <= lstate_d;
            rx_count_q  <= rx_count_d;
            pixels_q    <= pixels_d;
            load_done_q <= load_done_d;
        end
    end

    // Next-state, word capture and handshake.
    always_comb begin
        lstate_d    = lstate_q;
        rx_count_d  = rx_count_q;
        pixels_d    = pixels_q;
        load_done_d = 1'b0;
        in_ready_c  = 1'b0;
        pix_pad_c   = PAD_W'(pixels_q);

        unique case (lstate_q)
            L_IDLE: begin
                if (state == SEQ_LOAD) begin
                    lstate_d   = L_RECV;
                    rx_count_d = '0;
                end
            end
            L_RECV: begin
                if (state != SEQ_LOAD) begin
                    // Abort: keep partial image and count until next LOAD entry.
                    lstate_d = L_IDLE;
                end else begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        pix_pad_c[rx_count_q * IN_W +: IN_W] = bus.in_data;
                        pixels_d   = pix_pad_c[IMG_BITS-1:0];
                        rx_count_d = CW'(rx_count_q + CW'(1));
                        if (rx_count_q == CW'(WORDS - 1)) begin
                            lstate_d    = L_DONE;
                            load_done_d = 1'b1;
                        end
                    end
                end
            end
            L_DONE: begin
                if (state != SEQ_LOAD) begin
                    lstate_d = L_IDLE;
                end
            end
            default: begin
                lstate_d = L_IDLE;
            end
        endcase
    end

    assign bus.in_ready = in_ready_c;
    assign load_done    = load_done_q;
    assign rx_count     = rx_count_q;
    assign pixels       = pixels_q;
endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: full loads, stalls, abort, async reset, IN_W=16.
module tb_image_loader;
    localparam int unsigned IMG_BITS = 784;
    localparam int unsigned WORDS    = 98;
    localparam logic [2:0]  S_IDLE   = 3'b000;
    localparam logic [2:0]  S_LOAD   = 3'b001;
    localparam logic [2:0]  S_L1     = 3'b010;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] state;
    logic [2:0] state_b;

    always #5 clk = ~clk;

    image_loader_if #(.IN_W(8))  ifa ();
    image_loader_if #(.IN_W(16)) ifb ();

    logic                load_done;
    logic [6:0]          rx_count;
    logic [IMG_BITS-1:0] pixels;
    logic                load_done_b;
    logic [5:0]          rx_count_b;
    logic [IMG_BITS-1:0] pixels_b;

    image_loader #(.IMG_BITS(IMG_BITS), .IN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .bus       (ifa),
        .load_done (load_done),
        .rx_count  (rx_count),
        .pixels    (pixels)
    );

    image_loader #(.IMG_BITS(IMG_BITS), .IN_W(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state_b),
        .bus       (ifb),
        .load_done (load_done_b),
        .rx_count  (rx_count_b),
        .pixels    (pixels_b)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt   = 0;
    int done_cnt_b = 0;
    int exp_cnt;
    logic [IMG_BITS-1:0] exp_pix;

    // Count load_done pulses seen by the sequencer at each edge.
    always @(posedge clk) begin
        if (load_done === 1'b1)   done_cnt   <= done_cnt + 1;
        if (load_done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
    end

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [IMG_BITS-1:0] obs,
                       input logic [IMG_BITS-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word after `gap` idle cycles; update the model on accept.
    task automatic send_word(input logic [7:0] w, input int gap);
        int tries;
        for (int g = 0; g < gap; g++) begin
            ifa.in_valid = 1'b0;
            step();
            chk("stall_cnt", IMG_BITS'(rx_count), IMG_BITS'(exp_cnt));
        end
        ifa.in_valid = 1'b1;
        ifa.in_data  = w;
        tries = 0;
        while (ifa.in_ready !== 1'b1 && tries < 8) begin
            step();
            tries++;
        end
        chk("ready_wait", IMG_BITS'(ifa.in_ready), IMG_BITS'(1));
        step();
        exp_pix[exp_cnt*8 +: 8] = w;
        exp_cnt++;
        chk("rx_count", IMG_BITS'(rx_count), IMG_BITS'(exp_cnt));
        chk("load_done", IMG_BITS'(load_done), IMG_BITS'(exp_cnt == WORDS));
    endtask

    initial begin
        rst_n        = 1'b0;
        state        = S_IDLE;
        state_b      = S_IDLE;
        ifa.in_valid = 1'b0;
        ifa.in_data  = '0;
        ifb.in_valid = 1'b0;
        ifb.in_data  = '0;
        exp_pix      = '0;
        exp_cnt      = 0;
        #12;
        chk("rst_pixels", pixels, '0);
        chk("rst_rx", IMG_BITS'(rx_count), '0);
        chk("rst_done", IMG_BITS'(load_done), '0);
        chk("rst_ready", IMG_BITS'(ifa.in_ready), '0);
        rst_n = 1'b1;
        step();

        // Full load, valid held high, word k = k
        state = S_LOAD;
        #1;
        chk("ready_idle", IMG_BITS'(ifa.in_ready), '0);
        step();
        chk("ready_rise", IMG_BITS'(ifa.in_ready), IMG_BITS'(1));
        chk("rx_start", IMG_BITS'(rx_count), '0);
        done_cnt = 0;
        for (int k = 0; k < WORDS; k++) send_word(8'(k), 0);
        ifa.in_valid = 1'b0;
        chk("pix_full", pixels, exp_pix);
        chk("pix_b0", IMG_BITS'(pixels[7:0]), IMG_BITS'(8'h00));
        chk("pix_b1", IMG_BITS'(pixels[15:8]), IMG_BITS'(8'h01));
        chk("pix_b97", IMG_BITS'(pixels[783:776]), IMG_BITS'(8'h61));
        step();
        chk("done_fall", IMG_BITS'(load_done), '0);
        chk("done_once", IMG_BITS'(done_cnt), IMG_BITS'(1));

        // Stay in LOAD after done with junk offered
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("done_ready", IMG_BITS'(ifa.in_ready), '0);
        end
        ifa.in_valid = 1'b0;
        chk("done_pix", pixels, exp_pix);
        chk("done_rx", IMG_BITS'(rx_count), IMG_BITS'(WORDS));
        chk("done_single", IMG_BITS'(done_cnt), IMG_BITS'(1));

        // LAYER_1 -> IDLE -> LOAD restarts at word 0; reload with stalls
        state = S_L1;
        step();
        chk("l1_ready", IMG_BITS'(ifa.in_ready), '0);
        state = S_IDLE;
        step();
        state = S_LOAD;
        step();
        chk("reentry_rx", IMG_BITS'(rx_count), '0);
        exp_cnt  = 0;
        done_cnt = 0;
        for (int k = 0; k < WORDS; k++) send_word(8'(k), 2);
        ifa.in_valid = 1'b0;
        chk("gap_pix", pixels, exp_pix);
        step();
        chk("gap_done", IMG_BITS'(done_cnt), IMG_BITS'(1));

        // Abort after 40 words of AA
        state = S_IDLE;
        step();
        state = S_LOAD;
        step();
        exp_cnt  = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) send_word(8'hAA, 0);
        state = S_IDLE;
        step();
        ifa.in_valid = 1'b0;
        step();
        chk("abort_done", IMG_BITS'(done_cnt), '0);
        chk("abort_pix", pixels, exp_pix);
        chk("abort_rx", IMG_BITS'(rx_count), IMG_BITS'(40));
        state = S_LOAD;
        step();
        chk("abort_rx_clr", IMG_BITS'(rx_count), '0);
        exp_cnt = 0;
        for (int k = 0; k < WORDS; k++) send_word(8'(k), 0);
        ifa.in_valid = 1'b0;
        step();
        chk("reload_done", IMG_BITS'(done_cnt), IMG_BITS'(1));
        chk("reload_pix", pixels, exp_pix);

        // Async reset after 50 words
        state = S_IDLE;
        step();
        state = S_LOAD;
        step();
        exp_cnt = 0;
        for (int k = 0; k < 50; k++) send_word(8'(k) ^ 8'h3C, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pixels", pixels, '0);
        chk("arst_rx", IMG_BITS'(rx_count), '0);
        chk("arst_done", IMG_BITS'(load_done), '0);
        chk("arst_ready", IMG_BITS'(ifa.in_ready), '0);
        ifa.in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_pix = '0;
        exp_cnt = 0;
        step();
        done_cnt = 0;
        for (int k = 0; k < WORDS; k++) send_word(8'(k) ^ 8'h3C, 0);
        ifa.in_valid = 1'b0;
        step();
        chk("arst_reload_done", IMG_BITS'(done_cnt), IMG_BITS'(1));
        chk("arst_reload_pix", pixels, exp_pix);

        // IN_W=16 instance: 49 words, word k = {~k, k}
        state_b = S_LOAD;
        step();
        for (int k = 0; k < 49; k++) begin
            int tries;
            ifb.in_valid = 1'b1;
            ifb.in_data  = {~8'(k), 8'(k)};
            tries = 0;
            while (ifb.in_ready !== 1'b1 && tries < 8) begin
                step();
                tries++;
            end
            if (ifb.in_ready !== 1'b1) chk("w16_ready", IMG_BITS'(ifb.in_ready), IMG_BITS'(1));
            step();
        end
        ifb.in_valid = 1'b0;
        chk("w16_done_pulse", IMG_BITS'(load_done_b), IMG_BITS'(1));
        step();
        chk("w16_done", IMG_BITS'(done_cnt_b), IMG_BITS'(1));
        chk("w16_rx", IMG_BITS'(rx_count_b), IMG_BITS'(49));
        chk("w16_pix783", IMG_BITS'(pixels_b[783]), IMG_BITS'(1));
        chk("w16_word48", IMG_BITS'(pixels_b[783:768]), IMG_BITS'(16'hCF30));
        chk("w16_word0", IMG_BITS'(pixels_b[15:0]), IMG_BITS'(16'hFF00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Responder to the top-level inference sequencer: active while the sequencer's state bus reads LOAD (3'b001).
- Accepts the binarised input image as IN_W-bit words over a valid/ready handshake and packs it into an IMG_BITS-wide pixel register for layer 1.
- Issues the single-cycle load_done that advances the sequencer to LAYER_1.

Parameters:
- IMG_BITS, 784, number of binary pixels (28x28).
- IN_W, 8, input word width in bits.
- WORDS, ceil(IMG_BITS/IN_W) = 98, derived; words per image. Not for override.
- CW, clog2(WORDS+1) = 7, derived; counter width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- state  input  3  sequencer state: 000 IDLE, 001 LOAD, 010 LAYER_1, 011 LAYER_2, 100 LAYER_3.
- in_valid  input  1  in_data holds a valid word.
- in_data  input  IN_W  image word; bit j of word k is pixel k*IN_W+j.
- in_ready  output  1  loader accepts a word this cycle.
- load_done  output  1  one-cycle pulse when the full image has been captured.
- rx_count  output  CW  number of words accepted in the current load.
- pixels  output  IMG_BITS  packed image register, held for layer 1.

Behaviour:
- Reset (async, rst_n=0):
  - Internal FSM goes to L_IDLE.
  - rx_count=0, load_done=0, pixels=all zeros.
  - in_ready=0, because it is derived from the FSM state.
- Internal FSM states: L_IDLE, L_RECV, L_DONE.
- L_IDLE:
  - If state==LOAD: go to L_RECV and clear rx_count to 0.
  - Otherwise stay in L_IDLE.
  - No word is accepted in L_IDLE, so the first accept is possible 1 cycle after LOAD is first seen.
- L_RECV:
  - in_ready=1 (combinational; requires state==LOAD).
  - Accept when in_valid & in_ready: write the word into pixels[rx_count*IN_W +: IN_W], then increment rx_count.
  - Bits beyond IMG_BITS-1 in the last word are dropped; the pixel register never extends past IMG_BITS.
  - When the accepted word is number WORDS-1: go to L_DONE and register load_done=1 for exactly the next cycle.
  - in_valid=0 stalls the load indefinitely with no state change.
- L_DONE:
  - in_ready=0; in_valid is ignored and pixels is frozen.
  - load_done falls after its single cycle.
  - Stay in L_DONE while state==LOAD; when state!=LOAD go to L_IDLE.
  - rx_count holds at WORDS until the next LOAD entry.
- Latency: load_done is high in the cycle immediately after the handshake of the final word. The sequencer samples it at the next edge and moves to LAYER_1.
- Abort: if state leaves LOAD while in L_RECV:
  - Go to L_IDLE; no load_done is issued.
  - pixels keeps its partially overwritten content; rx_count holds its value until the next LOAD entry clears it.
- Re-entry: every new LOAD entry restarts at word 0. Old pixel content is overwritten word by word and not cleared up front.
- in_ready is 0 in every state other than LOAD, including during LAYER_1..3, so the image is stable through inference.
- Counter never wraps: rx_count saturates at WORDS because no accepts occur in L_DONE.
- Reset asserted mid-load: immediate return to reset values, pixels cleared.

Test Plan:
- Reset then state=LOAD; stream 98 words, word k = k[7:0], in_valid held high:
  - in_ready rises 1 cycle after LOAD; 98 accepts; load_done high for exactly 1 cycle after accept 98.
  - pixels[7:0]=8'h00, pixels[15:8]=8'h01, pixels[783:776]=8'h61; rx_count=98.
- Same stream with in_valid toggled 1-on/2-off:
  - Identical pixels; load_done comes after the 98th accept, not earlier.
  - rx_count tracks accepts exactly.
- After load_done, keep state=LOAD 5 cycles with in_valid=1, in_data=8'hFF:
  - in_ready=0 and pixels unchanged.
  - state=LAYER_1 then back to IDLE then LOAD: rx_count returns to 0 and loading restarts at word 0.
- Abort: state=LOAD, 40 words of 8'hAA, then state=IDLE:
  - No load_done; pixels[319:0] is all AA bytes and the rest is unchanged.
  - Re-enter LOAD and send 98 words: one load_done pulse only.
- Assert rst_n=0 asynchronously after 50 words:
  - pixels=0, rx_count=0, load_done=0, in_ready=0 immediately.
  - After release with state=LOAD, a full reload succeeds.
- Parameter check IN_W=16 (WORDS=49):
  - 49 words produce load_done.
  - Pixel 783 comes from word 48 bit 15.
